// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths, word addressing, buffer states and block slicing
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int BLOCK_WORDS = 16;
  localparam logic [4:0] ADDR_NONE = 5'd0;
  localparam logic [4:0] ADDR_FIRST = 5'd1;
  typedef enum logic {FILL = 1'b0, OFFER = 1'b1} buf_state_e;
  // W0 occupies the most significant word of a block
  function automatic int word_lsb(input int idx);
    return (BLOCK_WORDS - 1 - idx) * WORD_W;
  endfunction
endpackage

// File: rtl/word_reg_bank.sv
// word_reg_bank: 16x32 message word registers with written-word mask and flat block read
module word_reg_bank
  import sha256_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_i,
  input  logic                          clr_i,
  input  logic [3:0]                    idx_i,
  input  logic [WORD_W-1:0]             data_i,
  output logic [BLOCK_WORDS-1:0]        mask_o,
  output logic [WORD_W*BLOCK_WORDS-1:0] block_o
);
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] words_q;
  logic [BLOCK_WORDS-1:0]             mask_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_q <= '0;
      mask_q  <= '0;
    end else begin
      if (wr_i) words_q[idx_i] <= data_i;
      if (clr_i) mask_q <= '0;
      else if (wr_i) mask_q[idx_i] <= 1'b1;
    end
  end
  assign mask_o = mask_q;
  for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_slice
    assign block_o[word_lsb(g) +: WORD_W] = words_q[g];
  end
endmodule

// File: rtl/input_buffer.sv
// input_buffer: assembles a 512-bit SHA-256 block from host word writes and offers it to the core
module input_buffer
  import sha256_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int WORDS = BLOCK_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [4:0]             addr,
  input  logic [WIDTH-1:0]       in_var,
  input  logic                   first,
  input  logic                   go,
  input  logic                   clr,
  input  logic                   block_ack,
  output logic [WIDTH*WORDS-1:0] out_block,
  output logic                   block_valid,
  output logic                   block_first,
  output logic                   full,
  output logic                   busy,
  output logic                   err
);
  buf_state_e       state_q, state_d;
  logic             first_q, first_d, err_q, err_d;
  logic [WORDS-1:0] mask;
  logic [4:0]       addr_m1;
  logic             fill, valid_addr, wr, mask_full, handoff, bank_clr;
  assign fill       = state_q == FILL;
  assign addr_m1    = addr - ADDR_FIRST;
  assign valid_addr = addr != ADDR_NONE && addr <= 5'(WORDS);
  assign wr         = fill && we && valid_addr && !clr;
  assign mask_full  = &mask;
  // handoff judges the mask before any same-cycle write; clr takes priority
  assign handoff    = fill && go && mask_full && !clr;
  assign bank_clr   = fill ? clr : block_ack;
  word_reg_bank u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_i   (wr),
    .clr_i  (bank_clr),
    .idx_i  (addr_m1[3:0]),
    .data_i (in_var),
    .mask_o (mask),
    .block_o(out_block)
  );
  always_comb begin
    state_d = fill ? (handoff ? OFFER : FILL) : (block_ack ? FILL : OFFER);
    first_d = handoff ? first : first_q;
    err_d   = fill ? (clr ? 1'b0 : err_q | (go && !mask_full)) : err_q | we;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end
  assign block_valid = state_q == OFFER;
  assign busy        = block_valid;
  assign block_first = first_q;
  assign full        = mask_full;
  assign err         = err_q;
endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer: directed vector table plus reset corner sequences for input_buffer
module tb_input_buffer;
  logic         clk = 1'b0, rst_n = 1'b0, we = 1'b0, first = 1'b0, go = 1'b0, clr = 1'b0, block_ack = 1'b0;
  logic [4:0]   addr = '0;
  logic [31:0]  in_var = '0;
  logic [511:0] out_block;
  logic         block_valid, block_first, full, busy, err;
  int           n_cmp = 0, n_bad = 0;
  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        first, go, clr, ack;
    logic        ev, ef, ee, efst;
    logic        chk;
    int          cidx;
    logic [31:0] cval;
  } vec_t;
  vec_t v[$];
  input_buffer dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .in_var(in_var), .first(first),
    .go(go), .clr(clr), .block_ack(block_ack), .out_block(out_block),
    .block_valid(block_valid), .block_first(block_first), .full(full), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input int i);
    return out_block[(15 - i) * 32 +: 32];
  endfunction
  task automatic cmp(input string nm, input int step, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, got, exp);
    end
  endtask
  task automatic add(input logic w, input logic [4:0] a, input logic [31:0] d, input logic f, input logic g,
                     input logic c, input logic k, input logic ev, input logic ef, input logic ee, input logic efst);
    vec_t t;
    t = '{w, a, d, f, g, c, k, ev, ef, ee, efst, 1'b0, 0, 32'h0};
    v.push_back(t);
  endtask
  task automatic addc(input int i, input logic [31:0] val);
    v[v.size()-1].chk  = 1'b1;
    v[v.size()-1].cidx = i;
    v[v.size()-1].cval = val;
  endtask
  task automatic apply(input vec_t t);
    @(negedge clk);
    we = t.we; addr = t.addr; in_var = t.data; first = t.first; go = t.go; clr = t.clr; block_ack = t.ack;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // "abc" padded block, first of message
    for (int i = 0; i < 16; i++)
      add(1, 5'(i + 1), i == 0 ? 32'h61626380 : (i == 15 ? 32'h18 : 32'h0), 0, 0, 0, 0, 0, i == 15, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1); addc(0, 32'h61626380);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1); addc(15, 32'h18);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    // incomplete block: go errors, clr recovers and empties the mask
    for (int i = 0; i < 15; i++) add(1, 5'(i + 1), 32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    // write during OFFER is dropped and flagged
    add(1, 16, 32'h100F, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) add(1, 5'(i + 1), 32'h1000 + i, 0, 0, 0, 0, 0, i == 14, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0); addc(2, 32'h1002);
    add(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 1, 0); addc(2, 32'h1002);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0); addc(2, 32'h1002);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // no-op addresses, ack in FILL, rewrite, clr beats write
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0); addc(15, 32'h100F);
    add(1, 17, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0); addc(0, 32'h1000);
    add(1, 31, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0); addc(14, 32'h100E);
    add(1, 5, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 5, 32'h2, 0, 0, 0, 0, 0, 0, 0, 0); addc(4, 32'h2);
    for (int i = 0; i < 15; i++) if (i != 4) add(1, 5'(i + 1), 32'h3000 + i, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 16, 32'h300F, 0, 0, 0, 0, 0, 1, 0, 0); addc(4, 32'h2);
    add(1, 1, 32'hABCD, 0, 0, 1, 0, 0, 0, 0, 0); addc(0, 32'h3000);
    // go sees the pre-write mask; the following go hands off including W15
    for (int i = 0; i < 15; i++) add(1, 5'(i + 1), 32'h2000 + i, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 16, 32'h55, 1, 1, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1); addc(15, 32'h55);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_valid", -1, block_valid, 0);
    cmp("rst_busy", -1, busy, 0);
    cmp("rst_full", -1, full, 0);
    cmp("rst_err", -1, err, 0);
    cmp("rst_first", -1, block_first, 0);
    cmp("rst_block", -1, |out_block, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (v[i]) begin
      apply(v[i]);
      cmp("valid", i, block_valid, v[i].ev);
      cmp("busy", i, busy, v[i].ev);
      cmp("full", i, full, v[i].ef);
      cmp("err", i, err, v[i].ee);
      cmp("first", i, block_first, v[i].efst);
      if (v[i].chk) cmp($sformatf("word%0d", v[i].cidx), i, word(v[i].cidx), v[i].cval);
    end
    // reset while offering withdraws the block
    @(negedge clk);
    we = 0; go = 0; first = 0; clr = 0; block_ack = 0; rst_n = 1'b0;
    @(posedge clk);
    #1;
    cmp("offrst_valid", -1, block_valid, 0);
    cmp("offrst_busy", -1, busy, 0);
    cmp("offrst_full", -1, full, 0);
    cmp("offrst_err", -1, err, 0);
    cmp("offrst_first", -1, block_first, 0);
    cmp("offrst_w15", -1, word(15), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; block_ack = 1'b1;
    @(posedge clk);
    #1;
    cmp("lateack_valid", -1, block_valid, 0);
    cmp("lateack_err", -1, err, 0);
    cmp("lateack_full", -1, full, 0);
    @(negedge clk);
    block_ack = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/input_buffer.md
Name: input_buffer

Overview:
- Host-side write buffer that assembles one 512-bit SHA-256 message block from sixteen addressed 32-bit word writes.
- Hands the block to the hash core through a valid/ack handshake.
- Companion to the digest output buffer: same 1-based word addressing, opposite direction (host to core).
- Sits between the host bus and the compression-round controller.

Parameters:
- WIDTH, 32, word width in bits.
- WORDS, 16, words per block; the address width is fixed at 5 bits for this value.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- we  in  1  host write strobe.
- addr  in  5  word address; 1..16 select W0..W15; 0 and 17..31 are no-op.
- in_var  in  32  write data.
- first  in  1  sampled with go; marks the first block of a message, so the core re-initialises H0..H7.
- go  in  1  host request to hand the block to the core.
- clr  in  1  discard the partial block (mask and err only).
- block_ack  in  1  core has captured out_block.
- out_block  out  512  W0 in [511:480] through W15 in [31:0].
- block_valid  out  1  out_block is stable and offered to the core.
- block_first  out  1  copy of first latched at go.
- full  out  1  all 16 words written since the last handoff or clear.
- busy  out  1  equals block_valid; the host must not write.
- err  out  1  sticky host protocol error.

Behaviour:
- Reset and timing
  - Reset is synchronous: sampled only on the clk rising edge with rst_n=0.
  - On reset: word regs=0, mask=0, state=FILL, block_valid=0, block_first=0, full=0, busy=0, err=0.
  - All outputs are registered.
- States
  - FILL: host writes accepted; block_valid=0.
  - OFFER: block_valid=1; out_block and block_first are held constant.
- FILL writes: we with a valid address writes in_var to word addr-1 and sets mask bit addr-1 on the next edge.
  - Rewriting a word overwrites it; the mask is unchanged.
  - we with an invalid address: no state change, no error.
- full: registered, equal to &mask, visible the cycle after the 16th distinct write.
- FILL to OFFER: when go=1 and the registered mask is all ones (the value before any same-cycle write).
  - block_first latches first; block_valid rises on the next edge.
  - A same-cycle we still lands in the word regs, and that write is part of the offered block.
- go with an incomplete mask: err set; state stays FILL; mask kept.
- OFFER to FILL: when block_ack=1.
  - block_valid falls on the next edge; mask clears to 0; full falls.
  - Word regs keep their values; readback and reuse are allowed.
- block_ack in FILL is ignored.
- Host activity in OFFER:
  - we: ignored and sets err.
  - go: ignored, no error.
  - clr: ignored.
- clr in FILL: mask clears to 0 and err clears on the next edge; word regs are untouched.
  - clr with we in the same cycle: clr wins, and the write data is discarded.
- err is sticky; only clr in FILL or reset clears it.
- Reset in OFFER: returns to FILL with block_valid=0 on that edge. The core must treat the block as withdrawn.
- Latency:
  - write to mask update: 1 cycle.
  - go to block_valid: 1 cycle.
  - block_ack to block_valid low: 1 cycle.
  - Minimum handoff period: 18 cycles (16 writes, go, ack).

Decomposition:
- Shared package `sha256_pkg`:
  - WORD_W=32, BLOCK_WORDS=16.
  - ADDR_NONE=0, ADDR_FIRST=1.
  - Constants for the state encoding (FILL=0, OFFER=1).
  - Word-to-block bit-slice helper, shared with the output buffer.
- One natural sub-module, `word_reg_bank`: 16x32 register file with a write port and mask tracking, plus a flattened 512-bit read.
- The FSM and handshake stay in input_buffer.

Test Plan:
- Write the "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), then go with first=1:
  - full=1 after the 16th write.
  - block_valid=1 one cycle after go.
  - out_block[511:480]=0x61626380, out_block[31:0]=0x00000018, block_first=1.
  - block_ack returns block_valid=0 and full=0.
- Write W0..W14 only, then go: err=1, block_valid stays 0. Then clr: err=0, mask=0.
- In OFFER, we with addr=3 and data 0xDEADBEEF: out_block[447:416] unchanged, err=1. Then block_ack: back to FILL.
- Writes to addr=0 and addr=17: mask and words unchanged, err=0. Write addr=5 twice (0x1, then 0x2): word W4=0x2 and only one mask bit set.
- After 15 writes, issue we to addr=16 in the same cycle as go: no handoff (pre-write mask), err=1. Next go: OFFER with W15 present.
- Drive rst_n=0 for one cycle while in OFFER: block_valid=0, full=0, err=0 on that edge. A later block_ack has no effect.
